// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package mem_arb_pkg;

  localparam int unsigned AW_DEF = 12;
  localparam int unsigned DW_DEF = 16;
  localparam int unsigned WAIT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACCESS = 2'b01,
    ST_ACK    = 2'b10
  } state_t;

endpackage

// File: rtl/arb_rr2.sv
// Two-way round-robin picker: a lone request wins, a tie goes to the port not served last.
module arb_rr2 (
  input  logic req0,
  input  logic req1,
  input  logic last,
  output logic grant_valid,
  output logic grant_idx
);

  // Pick the winner among the active requests.
  always_comb begin
    grant_valid = req0 | req1;
    grant_idx   = 1'b0;
    if (req0 && req1) begin
      grant_idx = ~last;
    end else if (req1) begin
      grant_idx = 1'b1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Serializes two masters onto one memory port with round-robin fairness.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned AW   = AW_DEF,
  parameter int unsigned DW   = DW_DEF,
  parameter int unsigned WAIT = 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          req0,
  input  logic          we0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  output logic          ack0,
  output logic [DW-1:0] rdata0,
  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          ack1,
  output logic [DW-1:0] rdata1,
  output logic          mw,
  output logic [AW-1:0] maddr,
  output logic [DW-1:0] mwdata,
  input  logic [DW-1:0] mrdata,
  output logic          busy,
  output logic          owner
);

  state_t              state_q, state_d;
  logic                last_q, last_d;
  logic [WAIT_W-1:0]   cnt_q, cnt_d;
  logic                we_q, we_d;
  logic                mw_d, ack0_d, ack1_d, busy_d, owner_d;
  logic [AW-1:0]       maddr_d;
  logic [DW-1:0]       mwdata_d, rdata0_d, rdata1_d;
  logic                grant_valid, grant_idx;

  arb_rr2 u_arb (
    .req0        (req0),
    .req1        (req1),
    .last        (last_q),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  // Next-state and next-output logic; maddr/mwdata double as the latched request.
  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    cnt_d    = cnt_q;
    we_d     = we_q;
    maddr_d  = maddr;
    mwdata_d = mwdata;
    owner_d  = owner;
    rdata0_d = rdata0;
    rdata1_d = rdata1;
    mw_d     = 1'b0;
    ack0_d   = 1'b0;
    ack1_d   = 1'b0;
    busy_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (grant_valid) begin
          state_d  = ST_ACCESS;
          owner_d  = grant_idx;
          we_d     = grant_idx ? we1 : we0;
          maddr_d  = grant_idx ? addr1 : addr0;
          mwdata_d = grant_idx ? wdata1 : wdata0;
          cnt_d    = WAIT_W'(WAIT);
          mw_d     = grant_idx ? we1 : we0;
          busy_d   = 1'b1;
        end
      end
      ST_ACCESS: begin
        busy_d = 1'b1;
        if (cnt_q == '0) begin
          state_d = ST_ACK;
          if (owner) begin
            ack1_d = 1'b1;
            if (!we_q) rdata1_d = mrdata;
          end else begin
            ack0_d = 1'b1;
            if (!we_q) rdata0_d = mrdata;
          end
        end else begin
          cnt_d = cnt_q - WAIT_W'(1);
          mw_d  = we_q;
        end
      end
      ST_ACK: begin
        state_d = ST_IDLE;
        last_d  = owner;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      last_q  <= 1'b1;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      mw      <= 1'b0;
      ack0    <= 1'b0;
      ack1    <= 1'b0;
      busy    <= 1'b0;
      owner   <= 1'b0;
      maddr   <= '0;
      mwdata  <= '0;
      rdata0  <= '0;
      rdata1  <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      mw      <= mw_d;
      ack0    <= ack0_d;
      ack1    <= ack1_d;
      busy    <= busy_d;
      owner   <= owner_d;
      maddr   <= maddr_d;
      mwdata  <= mwdata_d;
      rdata0  <= rdata0_d;
      rdata1  <= rdata1_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: transaction-level timing model plus a WAIT=0 instance.
module tb_mem_arbiter;

  localparam int AW   = 12;
  localparam int DW   = 16;
  localparam int WAIT = 1;

  logic clock = 1'b0;
  logic reset;

  logic [1:0]    req, we, ack;
  logic [AW-1:0] addr  [2];
  logic [DW-1:0] wdata [2];
  logic [DW-1:0] rdata [2];
  logic          mw, busy, owner;
  logic [AW-1:0] maddr;
  logic [DW-1:0] mwdata, mrdata;

  logic          z_req0, z_we0, z_ack0, z_req1, z_we1, z_ack1;
  logic [AW-1:0] z_addr0, z_addr1, z_maddr;
  logic [DW-1:0] z_wdata0, z_wdata1, z_rdata0, z_rdata1, z_mwdata, z_mrdata;
  logic          z_mw, z_busy, z_owner;

  always #5 clock = ~clock;

  mem_arbiter #(.AW(AW), .DW(DW), .WAIT(WAIT)) dut (
    .clock(clock), .reset(reset),
    .req0(req[0]), .we0(we[0]), .addr0(addr[0]), .wdata0(wdata[0]), .ack0(ack[0]), .rdata0(rdata[0]),
    .req1(req[1]), .we1(we[1]), .addr1(addr[1]), .wdata1(wdata[1]), .ack1(ack[1]), .rdata1(rdata[1]),
    .mw(mw), .maddr(maddr), .mwdata(mwdata), .mrdata(mrdata), .busy(busy), .owner(owner)
  );

  mem_arbiter #(.AW(AW), .DW(DW), .WAIT(0)) dut_z (
    .clock(clock), .reset(reset),
    .req0(z_req0), .we0(z_we0), .addr0(z_addr0), .wdata0(z_wdata0), .ack0(z_ack0), .rdata0(z_rdata0),
    .req1(z_req1), .we1(z_we1), .addr1(z_addr1), .wdata1(z_wdata1), .ack1(z_ack1), .rdata1(z_rdata1),
    .mw(z_mw), .maddr(z_maddr), .mwdata(z_mwdata), .mrdata(z_mrdata), .busy(z_busy), .owner(z_owner)
  );

  // Byte-wide big-endian memory behind the main instance.
  logic [7:0] mem [4096];
  assign mrdata = {mem[maddr], mem[maddr + 12'd1]};
  always @(posedge clock) begin
    if (mw === 1'b1) begin
      mem[maddr]         <= mwdata[15:8];
      mem[maddr + 12'd1] <= mwdata[7:0];
    end
  end

  function automatic logic [15:0] z_word(input logic [11:0] a);
    return 16'(a) ^ 16'hA5A5;
  endfunction
  assign z_mrdata = z_word(z_maddr);

  function automatic logic [7:0] init_byte(input int a);
    return 8'((a * 7 + 3) % 256);
  endfunction

  // Reference model state
  int checks = 0;
  int errors = 0;
  int edge_n = 0;
  bit pend [2];
  bit granted [2];
  logic          t_we [2];
  logic [AW-1:0] t_addr [2];
  logic [DW-1:0] t_wd [2];
  bit active;
  int cur, g_edge, ack_edge, free_edge, last_p, owner_exp;
  logic [DW-1:0] exp_rdata [2];
  logic [DW-1:0] shadow [int];
  int unsigned rate [2];
  int unsigned wr_pct;
  bit scramble;
  int ack_port_q [$];
  int ack_edge_q [$];

  function automatic logic [15:0] rd_word(input logic [11:0] a);
    if (shadow.exists(int'(a))) return shadow[int'(a)];
    return {init_byte(int'(a)), init_byte(int'(a) + 1)};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    edge_n++;
  endtask

  task automatic issue(input int p, input logic w, input logic [11:0] a, input logic [15:0] d);
    pend[p] = 1'b1; granted[p] = 1'b0;
    t_we[p] = w; t_addr[p] = a; t_wd[p] = d;
    req[p] = 1'b1; we[p] = w; addr[p] = a; wdata[p] = d;
  endtask

  task automatic scr(input int p);
    we[p]    = 1'($urandom_range(1));
    addr[p]  = 12'($urandom);
    wdata[p] = 16'($urandom);
  endtask

  // Compare every output against the transaction timeline for the cycle after edge_n.
  task automatic observe();
    int n = edge_n;
    bit in_acc = active && (n >= g_edge) && (n <= g_edge + WAIT);
    bit is_ack = active && (n == ack_edge);
    if (is_ack) begin
      if (!t_we[cur]) exp_rdata[cur] = rd_word(t_addr[cur]);
      else shadow[int'(t_addr[cur])] = t_wd[cur];
    end
    if (ack[0] === 1'b1) begin ack_port_q.push_back(0); ack_edge_q.push_back(n); end
    if (ack[1] === 1'b1) begin ack_port_q.push_back(1); ack_edge_q.push_back(n); end
    check("ack0", 32'(ack[0]), 32'(is_ack && cur == 0));
    check("ack1", 32'(ack[1]), 32'(is_ack && cur == 1));
    check("busy", 32'(busy), 32'(in_acc || is_ack));
    check("mw", 32'(mw), 32'(in_acc && t_we[cur]));
    check("owner", 32'(owner), 32'(owner_exp));
    if (in_acc) begin
      check("maddr", 32'(maddr), 32'(t_addr[cur]));
      if (t_we[cur]) check("mwdata", 32'(mwdata), 32'(t_wd[cur]));
    end
    check("rdata0", 32'(rdata[0]), 32'(exp_rdata[0]));
    check("rdata1", 32'(rdata[1]), 32'(exp_rdata[1]));
    if (is_ack) begin
      pend[cur] = 1'b0; granted[cur] = 1'b0; active = 1'b0;
    end
  endtask

  // Choose requester inputs for the next edge.
  task automatic stim();
    for (int p = 0; p < 2; p++) begin
      if (!pend[p]) begin
        if ($urandom_range(99) < rate[p])
          issue(p, 1'($urandom_range(99) < wr_pct), 12'h100 + 12'(2 * $urandom_range(31)), 16'($urandom));
        else begin
          req[p] = 1'b0;
          if (scramble) scr(p);
        end
      end else if (granted[p] && scramble) begin
        scr(p);
        req[p] = 1'($urandom_range(1));
      end
    end
  endtask

  // Decide whether the next edge starts an access, and for whom.
  task automatic grant();
    int n1 = edge_n + 1;
    bit r0 = pend[0] && !granted[0];
    bit r1 = pend[1] && !granted[1];
    if (!active && n1 >= free_edge && (r0 || r1)) begin
      cur = (r0 && r1) ? 1 - last_p : (r1 ? 1 : 0);
      active = 1'b1; granted[cur] = 1'b1;
      g_edge = n1; ack_edge = n1 + WAIT + 1; free_edge = n1 + WAIT + 3;
      last_p = cur; owner_exp = cur;
    end
  endtask

  task automatic run(input int k);
    repeat (k) begin
      tick(); observe(); stim(); grant();
    end
  endtask

  task automatic model_reset();
    active = 1'b0; last_p = 1; owner_exp = 0; free_edge = edge_n + 1;
    exp_rdata[0] = '0; exp_rdata[1] = '0;
    for (int p = 0; p < 2; p++) begin pend[p] = 1'b0; granted[p] = 1'b0; end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ack0"}, 32'(ack[0]), 32'd0);
    check({tag, "_ack1"}, 32'(ack[1]), 32'd0);
    check({tag, "_mw"}, 32'(mw), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_owner"}, 32'(owner), 32'd0);
    check({tag, "_maddr"}, 32'(maddr), 32'd0);
    check({tag, "_mwdata"}, 32'(mwdata), 32'd0);
    check({tag, "_rdata0"}, 32'(rdata[0]), 32'd0);
    check({tag, "_rdata1"}, 32'(rdata[1]), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int exp_first, zk, z_last, z_t;
    logic [11:0] z_cur;

    for (int i = 0; i < 4096; i++) mem[i] <= init_byte(i);
    mem[16] <= 8'h12;
    mem[17] <= 8'h34;
    shadow[16] = 16'h1234;

    z_req0 = 1'b0; z_we0 = 1'b0; z_addr0 = '0; z_wdata0 = '0;
    z_req1 = 1'b0; z_we1 = 1'b0; z_addr1 = '0; z_wdata1 = '0;
    rate[0] = 0; rate[1] = 0; wr_pct = 0; scramble = 1'b0;

    // Reset held two cycles with both ports requesting.
    reset = 1'b1;
    req = 2'b11; we = 2'b00;
    addr[0] = 12'h040; addr[1] = 12'h042; wdata[0] = '0; wdata[1] = '0;
    repeat (2) begin
      tick();
      check_reset_outputs("rst");
    end
    reset = 1'b0;
    model_reset();
    issue(0, 1'b0, 12'h040, '0);
    issue(1, 1'b0, 12'h042, '0);
    grant();
    run(12);

    // Single port-0 read of a preloaded word.
    issue(0, 1'b0, 12'h010, '0);
    grant();
    run(6);
    check("p0_read_0x010", 32'(rdata[0]), 32'h1234);

    // Port-1 write followed by a port-0 read of the same word.
    issue(1, 1'b1, 12'h020, 16'hBEEF);
    grant();
    run(6);
    issue(0, 1'b0, 12'h020, '0);
    grant();
    run(6);
    check("p0_read_back", 32'(rdata[0]), 32'hBEEF);

    // Both ports requesting continuously.
    exp_first = 1 - last_p;
    ack_port_q.delete(); ack_edge_q.delete();
    rate[0] = 100; rate[1] = 100; wr_pct = 50;
    stim(); grant();
    run(18);
    check("cont_ack_count_ge4", 32'(ack_port_q.size() >= 4), 32'd1);
    for (int i = 0; i < 4; i++) begin
      if (i < ack_port_q.size()) begin
        check("cont_order", 32'(ack_port_q[i]), 32'((exp_first + i) % 2));
        if (i > 0) check("cont_spacing", 32'(ack_edge_q[i] - ack_edge_q[i-1]), 32'(WAIT + 3));
      end
    end
    rate[0] = 0; rate[1] = 0;
    run(8);

    // Randomized traffic with input scrambling and mid-access req drops.
    rate[0] = 40; rate[1] = 35; wr_pct = 40; scramble = 1'b1;
    run(3000);
    rate[0] = 0; rate[1] = 0; scramble = 1'b0;
    run(12);

    // Reset during the second ACCESS cycle of a write.
    issue(1, 1'b1, 12'h030, 16'h5A5A);
    grant();
    run(2);
    check("mid_write_mw_before", 32'(mw), 32'd1);
    reset = 1'b1;
    req = 2'b00;
    tick();
    check("mid_rst_mw", 32'(mw), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_ack0", 32'(ack[0]), 32'd0);
    check("mid_rst_ack1", 32'(ack[1]), 32'd0);
    check("mid_rst_owner", 32'(owner), 32'd0);
    reset = 1'b0;
    shadow[48] = 16'h5A5A;
    model_reset();
    run(2);
    issue(0, 1'b0, 12'h030, '0);
    grant();
    run(6);
    check("after_rst_read", 32'(rdata[0]), 32'h5A5A);

    // WAIT=0 instance: first ack two cycles after the request, then one every 3 cycles.
    z_cur = 12'h055;
    z_addr0 = z_cur;
    z_req0 = 1'b1;
    z_t = edge_n + 1;
    zk = 0;
    z_last = 0;
    for (int c = 0; c < 40 && zk < 4; c++) begin
      tick();
      check("z_mw", 32'(z_mw), 32'd0);
      check("z_ack1", 32'(z_ack1), 32'd0);
      if (z_ack0 === 1'b1) begin
        if (zk == 0) check("z_first_ack_edge", 32'(edge_n), 32'(z_t + 1));
        else check("z_ack_spacing", 32'(edge_n - z_last), 32'd3);
        check("z_rdata0", 32'(z_rdata0), 32'(z_word(z_cur)));
        z_last = edge_n;
        zk++;
        z_cur = z_cur + 12'h2;
        z_addr0 = z_cur;
      end
    end
    check("z_ack_count", 32'(zk), 32'd4);
    z_req0 = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
